// File: rtl/l2_lmem_pkg.sv
// Shared definitions for the banked L2 local memory: default geometry, derived widths,
// the INVALID coherence state, the controller FSM encoding and the tag/state entry layout.
package l2_lmem_pkg;

    localparam int DEF_NUM_WAYS       = 8;
    localparam int DEF_NUM_SETS       = 512;
    localparam int DEF_BANK_DEPTH     = 256;
    localparam int DEF_WORDS_PER_LINE = 2;
    localparam int DEF_WORD_BITS      = 64;
    localparam int DEF_TAG_BITS       = 16;
    localparam int DEF_STATE_BITS     = 3;
    localparam int DEF_HPROT_BITS     = 1;

    localparam int SET_BITS      = $clog2(DEF_NUM_SETS);
    localparam int WAY_BITS      = $clog2(DEF_NUM_WAYS);
    localparam int BANK_SEL_BITS = $clog2(DEF_NUM_SETS / DEF_BANK_DEPTH);

    localparam logic [DEF_STATE_BITS-1:0] INVALID = '0;

    typedef enum logic {INIT, IDLE} lmem_fsm_t;

    typedef struct packed {
        logic [DEF_HPROT_BITS-1:0]                          hprot;
        logic [DEF_WORDS_PER_LINE-1:0][DEF_STATE_BITS-1:0]  state;
        logic [DEF_TAG_BITS-1:0]                            tag;
    } lmem_entry_t;

    // Width of a select field; a single bank still gets a one-bit (constant zero) select.
    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_lmem_way.sv
// One way of the L2 local memory: all SRAM banks of the way, bank write decode and the
// registered read mux. Parity storage/check is built only with L2_LMEM_PARITY_EN defined.
module l2_lmem_way
    import l2_lmem_pkg::*;
#(
    parameter int NUM_SETS       = DEF_NUM_SETS,
    parameter int BANK_DEPTH     = DEF_BANK_DEPTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int WORD_BITS      = DEF_WORD_BITS,
    parameter int TAG_BITS       = DEF_TAG_BITS,
    parameter int STATE_BITS     = DEF_STATE_BITS,
    parameter int HPROT_BITS     = DEF_HPROT_BITS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rd_en,
    input  logic                                 init,
    input  logic [$clog2(NUM_SETS)-1:0]          set_addr,
    input  logic                                 wr_en_line,
    input  logic                                 wr_en_tag,
    input  logic [WORDS_PER_LINE-1:0]            wr_en_state,
    input  logic [WORDS_PER_LINE*WORD_BITS-1:0]  wr_data_line,
    input  logic [TAG_BITS-1:0]                  wr_data_tag,
    input  logic [HPROT_BITS-1:0]                wr_data_hprot,
    input  logic [WORDS_PER_LINE*STATE_BITS-1:0] wr_data_state,
    output logic [WORDS_PER_LINE*WORD_BITS-1:0]  rd_line,
    output logic [TAG_BITS-1:0]                  rd_tag,
    output logic [HPROT_BITS-1:0]                rd_hprot,
    output logic [WORDS_PER_LINE*STATE_BITS-1:0] rd_state
`ifdef L2_LMEM_PARITY_EN
    ,
    output logic                                 parity_err
`endif
);

    localparam int NUM_BANKS = NUM_SETS / BANK_DEPTH;
    localparam int ADDR_W    = $clog2(BANK_DEPTH);
    localparam int BSEL_W    = sel_bits(NUM_BANKS);
    localparam int LINE_W    = WORDS_PER_LINE * WORD_BITS;
    localparam int STATE_W   = WORDS_PER_LINE * STATE_BITS;
    localparam int TH_W      = HPROT_BITS + TAG_BITS;

    logic [ADDR_W-1:0] addr;
    logic [BSEL_W-1:0] bank, bank_q;

    assign addr = set_addr[ADDR_W-1:0];
    assign bank = BSEL_W'(set_addr >> ADDR_W);

    logic [TH_W-1:0]    th_mem    [NUM_BANKS][BANK_DEPTH];
    logic [STATE_W-1:0] state_mem [NUM_BANKS][BANK_DEPTH];
    logic [LINE_W-1:0]  line_mem  [NUM_BANKS][BANK_DEPTH];

    logic [TH_W-1:0]    th_q    [NUM_BANKS];
    logic [STATE_W-1:0] state_q [NUM_BANKS];
    logic [LINE_W-1:0]  line_q  [NUM_BANKS];

    // The init sweep forces an all-INVALID, zero-tag entry and never touches line data.
    logic                      tag_we, line_we;
    logic [WORDS_PER_LINE-1:0] state_we;
    logic [TH_W-1:0]           th_wdata;
    logic [STATE_W-1:0]        state_wdata;

    assign tag_we      = init | wr_en_tag;
    assign line_we     = wr_en_line & ~init;
    assign state_we    = init ? '1 : wr_en_state;
    assign th_wdata    = init ? '0 : {wr_data_hprot, wr_data_tag};
    assign state_wdata = init ? {WORDS_PER_LINE{STATE_BITS'(INVALID)}} : wr_data_state;

    // NOTE: SRAM arrays carry no reset; only the init sweep clears tag/state contents.
    always_ff @(posedge clk) begin
        if (tag_we)  th_mem[bank][addr]   <= th_wdata;
        if (line_we) line_mem[bank][addr] <= wr_data_line;
        for (int k = 0; k < WORDS_PER_LINE; k++)
            if (state_we[k])
                state_mem[bank][addr][k*STATE_BITS +: STATE_BITS] <= state_wdata[k*STATE_BITS +: STATE_BITS];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_q <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                th_q[b]    <= '0;
                state_q[b] <= '0;
                line_q[b]  <= '0;
            end
        end else if (rd_en) begin
            bank_q <= bank;
            for (int b = 0; b < NUM_BANKS; b++) begin
                th_q[b]    <= th_mem[b][addr];
                state_q[b] <= state_mem[b][addr];
                line_q[b]  <= line_mem[b][addr];
            end
        end
    end

    // Mux on the registered bank so set_addr may move on while rd_valid is high.
    assign rd_tag   = th_q[bank_q][TAG_BITS-1:0];
    assign rd_hprot = th_q[bank_q][TH_W-1:TAG_BITS];
    assign rd_state = state_q[bank_q];
    assign rd_line  = line_q[bank_q];

`ifdef L2_LMEM_PARITY_EN
    logic                      th_par_mem    [NUM_BANKS][BANK_DEPTH];
    logic [WORDS_PER_LINE-1:0] state_par_mem [NUM_BANKS][BANK_DEPTH];
    logic [WORDS_PER_LINE-1:0] line_par_mem  [NUM_BANKS][BANK_DEPTH];
    logic                      th_par_q      [NUM_BANKS];
    logic [WORDS_PER_LINE-1:0] state_par_q   [NUM_BANKS];
    logic [WORDS_PER_LINE-1:0] line_par_q    [NUM_BANKS];

    always_ff @(posedge clk) begin
        if (tag_we) th_par_mem[bank][addr] <= ^th_wdata;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            if (state_we[k]) state_par_mem[bank][addr][k] <= ^state_wdata[k*STATE_BITS +: STATE_BITS];
            if (line_we)     line_par_mem[bank][addr][k]  <= ^wr_data_line[k*WORD_BITS +: WORD_BITS];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                th_par_q[b]    <= 1'b0;
                state_par_q[b] <= '0;
                line_par_q[b]  <= '0;
            end
        end else if (rd_en) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                th_par_q[b]    <= th_par_mem[b][addr];
                state_par_q[b] <= state_par_mem[b][addr];
                line_par_q[b]  <= line_par_mem[b][addr];
            end
        end
    end

    always_comb begin
        parity_err = (^th_q[bank_q]) ^ th_par_q[bank_q];
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            parity_err = parity_err | ((^rd_state[k*STATE_BITS +: STATE_BITS]) ^ state_par_q[bank_q][k]);
            parity_err = parity_err | ((^rd_line[k*WORD_BITS +: WORD_BITS]) ^ line_par_q[bank_q][k]);
        end
    end
`endif

endmodule

// File: rtl/l2_localmem_banked.sv
// Banked, parametrised L2 local memory: init sweep FSM, NUM_WAYS way slices and the
// per-set evict-way pointers. Define L2_LMEM_PARITY_EN to add parity storage and parity_err.
module l2_localmem_banked
    import l2_lmem_pkg::*;
#(
    parameter int NUM_WAYS       = DEF_NUM_WAYS,
    parameter int NUM_SETS       = DEF_NUM_SETS,
    parameter int BANK_DEPTH     = DEF_BANK_DEPTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int WORD_BITS      = DEF_WORD_BITS,
    parameter int TAG_BITS       = DEF_TAG_BITS,
    parameter int STATE_BITS     = DEF_STATE_BITS,
    parameter int HPROT_BITS     = DEF_HPROT_BITS
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          rd_en,
    input  logic [$clog2(NUM_SETS)-1:0]                   set_in,
    input  logic [$clog2(NUM_WAYS)-1:0]                   way_in,
    input  logic                                          wr_en_line,
    input  logic [WORDS_PER_LINE-1:0]                     wr_en_state,
    input  logic                                          wr_en_tag,
    input  logic                                          wr_en_evict_way,
    input  logic                                          evict_advance,
    input  logic [WORDS_PER_LINE*WORD_BITS-1:0]           wr_data_line,
    input  logic [TAG_BITS-1:0]                           wr_data_tag,
    input  logic [HPROT_BITS-1:0]                         wr_data_hprot,
    input  logic [WORDS_PER_LINE*STATE_BITS-1:0]          wr_data_state,
    input  logic [$clog2(NUM_WAYS)-1:0]                   wr_data_evict_way,
    output logic                                          ready,
    output logic                                          rd_valid,
    output logic [NUM_WAYS*WORDS_PER_LINE*WORD_BITS-1:0]  rd_data_line,
    output logic [NUM_WAYS*TAG_BITS-1:0]                  rd_data_tag,
    output logic [NUM_WAYS*HPROT_BITS-1:0]                rd_data_hprot,
    output logic [NUM_WAYS*WORDS_PER_LINE*STATE_BITS-1:0] rd_data_state,
    output logic [$clog2(NUM_WAYS)-1:0]                   rd_data_evict_way
`ifdef L2_LMEM_PARITY_EN
    ,
    output logic [NUM_WAYS-1:0]                           parity_err
`endif
);

    localparam int SET_W   = $clog2(NUM_SETS);
    localparam int WAY_W   = $clog2(NUM_WAYS);
    localparam int LINE_W  = WORDS_PER_LINE * WORD_BITS;
    localparam int STATE_W = WORDS_PER_LINE * STATE_BITS;

    lmem_fsm_t        fsm;
    logic [SET_W-1:0] init_set;

    // ready is registered alongside the INIT->IDLE move, so it rises the cycle after set NUM_SETS-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm      <= INIT;
            init_set <= '0;
            ready    <= 1'b0;
        end else begin
            case (fsm)
                INIT: begin
                    if (init_set == SET_W'(NUM_SETS - 1)) begin
                        fsm   <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        init_set <= init_set + SET_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    logic             init, rd_accept;
    logic [SET_W-1:0] set_sel;

    assign init      = (fsm == INIT);
    assign rd_accept = ready & rd_en;
    assign set_sel   = init ? init_set : set_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_valid <= 1'b0;
        else      rd_valid <= rd_accept;
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        logic way_sel;
        assign way_sel = ready && (way_in == WAY_W'(w));

        l2_lmem_way #(
            .NUM_SETS       (NUM_SETS),
            .BANK_DEPTH     (BANK_DEPTH),
            .WORDS_PER_LINE (WORDS_PER_LINE),
            .WORD_BITS      (WORD_BITS),
            .TAG_BITS       (TAG_BITS),
            .STATE_BITS     (STATE_BITS),
            .HPROT_BITS     (HPROT_BITS)
        ) u_way (
            .clk           (clk),
            .rst           (rst),
            .rd_en         (rd_accept),
            .init          (init),
            .set_addr      (set_sel),
            .wr_en_line    (way_sel & wr_en_line),
            .wr_en_tag     (way_sel & wr_en_tag),
            .wr_en_state   (way_sel ? wr_en_state : '0),
            .wr_data_line  (wr_data_line),
            .wr_data_tag   (wr_data_tag),
            .wr_data_hprot (wr_data_hprot),
            .wr_data_state (wr_data_state),
            .rd_line       (rd_data_line[w*LINE_W +: LINE_W]),
            .rd_tag        (rd_data_tag[w*TAG_BITS +: TAG_BITS]),
            .rd_hprot      (rd_data_hprot[w*HPROT_BITS +: HPROT_BITS]),
            .rd_state      (rd_data_state[w*STATE_W +: STATE_W])
`ifdef L2_LMEM_PARITY_EN
            ,
            .parity_err    (parity_err[w])
`endif
        );
    end

    // Evict pointers: explicit load beats advance; a same-cycle read sees the old value.
    logic [WAY_W-1:0] evict_ptr [NUM_SETS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SETS; s++) evict_ptr[s] <= '0;
            rd_data_evict_way <= '0;
        end else if (ready) begin
            if (wr_en_evict_way)    evict_ptr[set_in] <= wr_data_evict_way;
            else if (evict_advance) evict_ptr[set_in] <= evict_ptr[set_in] + WAY_W'(1);
            if (rd_en)              rd_data_evict_way <= evict_ptr[set_in];
        end
    end

endmodule

// File: tb/tb_l2_localmem_banked.sv
// Directed, table-driven bench for l2_localmem_banked at default geometry (8 ways, 512 sets).
// Parity corner is exercised only when L2_LMEM_PARITY_EN is defined.
module tb_l2_localmem_banked;

    localparam logic [127:0] L1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] L2 = 128'hDEAD_BEEF_0000_1111_CAFE_F00D_2222_3333;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_en;
    logic [8:0]   set_in;
    logic [2:0]   way_in;
    logic         wr_en_line;
    logic [1:0]   wr_en_state;
    logic         wr_en_tag;
    logic         wr_en_evict_way;
    logic         evict_advance;
    logic [127:0] wr_data_line;
    logic [15:0]  wr_data_tag;
    logic         wr_data_hprot;
    logic [5:0]   wr_data_state;
    logic [2:0]   wr_data_evict_way;
    logic         ready;
    logic         rd_valid;
    logic [1023:0] rd_data_line;
    logic [127:0] rd_data_tag;
    logic [7:0]   rd_data_hprot;
    logic [47:0]  rd_data_state;
    logic [2:0]   rd_data_evict_way;
`ifdef L2_LMEM_PARITY_EN
    logic [7:0]   parity_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l2_localmem_banked dut (
        .clk               (clk),
        .rst               (rst),
        .rd_en             (rd_en),
        .set_in            (set_in),
        .way_in            (way_in),
        .wr_en_line        (wr_en_line),
        .wr_en_state       (wr_en_state),
        .wr_en_tag         (wr_en_tag),
        .wr_en_evict_way   (wr_en_evict_way),
        .evict_advance     (evict_advance),
        .wr_data_line      (wr_data_line),
        .wr_data_tag       (wr_data_tag),
        .wr_data_hprot     (wr_data_hprot),
        .wr_data_state     (wr_data_state),
        .wr_data_evict_way (wr_data_evict_way),
        .ready             (ready),
        .rd_valid          (rd_valid),
        .rd_data_line      (rd_data_line),
        .rd_data_tag       (rd_data_tag),
        .rd_data_hprot     (rd_data_hprot),
        .rd_data_state     (rd_data_state),
        .rd_data_evict_way (rd_data_evict_way)
`ifdef L2_LMEM_PARITY_EN
        ,
        .parity_err        (parity_err)
`endif
    );

    typedef struct {
        logic         rd_en;
        logic [8:0]   set;
        logic [2:0]   way;
        logic         wl;
        logic [1:0]   ws;
        logic         wt;
        logic [127:0] line;
        logic [15:0]  tag;
        logic         hprot;
        logic [5:0]   state;
        logic [3:0]   cmp;        // {valid, tag+hprot, state, line}
        logic         exp_valid;
        logic [127:0] exp_line;
        logic [15:0]  exp_tag;
        logic         exp_hprot;
        logic [5:0]   exp_state;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        rd_en = 1'b0; wr_en_line = 1'b0; wr_en_state = '0; wr_en_tag = 1'b0;
        wr_en_evict_way = 1'b0; evict_advance = 1'b0;
    endtask

    task automatic read_set(input logic [8:0] s);
        set_in = s; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 600) begin
            tick();
            n++;
        end
        check(name, 128'(n), 128'd512);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_valid;
        clear_req();
        rst = 1'b0; set_in = '0; way_in = '0;
        wr_data_line = '0; wr_data_tag = '0; wr_data_hprot = 1'b0;
        wr_data_state = '0; wr_data_evict_way = '0;
        #12;
        check("rst_ready", 128'(ready), 128'd0);
        check("rst_rd_valid", 128'(rd_valid), 128'd0);
        check("rst_tags_zero", 128'(|rd_data_tag), 128'd0);
        check("rst_lines_zero", 128'(|rd_data_line), 128'd0);
        check("rst_evict_zero", 128'(rd_data_evict_way), 128'd0);

        // Requests during INIT must be ignored, including evict advances on set 10.
        tick();
        rst = 1'b1;
        rd_en = 1'b1; set_in = 9'd10; evict_advance = 1'b1;
        saw_valid = 1'b0;
        begin
            int n = 0;
            while (!ready && n < 600) begin
                tick();
                n++;
                saw_valid |= rd_valid;
            end
            check("init_cycles", 128'(n), 128'd512);
        end
        clear_req();
        check("no_rd_valid_in_init", 128'(saw_valid), 128'd0);

        read_set(9'd37);
        check("set37_rd_valid", 128'(rd_valid), 128'd1);
        check("set37_tags", rd_data_tag, 128'd0);
        check("set37_states", 128'(rd_data_state), 128'd0);
        tick();
        check("rd_valid_drop", 128'(rd_valid), 128'd0);

        vecs[0] = '{1'b0, 9'd300, 3'd3, 1'b0, 2'b11, 1'b1, 128'd0, 16'h1A2B, 1'b1, 6'h11,
                    4'b0000, 1'b0, 128'd0, 16'h0, 1'b0, 6'h00};
        vecs[1] = '{1'b0, 9'd300, 3'd3, 1'b0, 2'b01, 1'b0, 128'd0, 16'h0, 1'b0, 6'h3C,
                    4'b0000, 1'b0, 128'd0, 16'h0, 1'b0, 6'h00};
        vecs[2] = '{1'b1, 9'd300, 3'd3, 1'b0, 2'b00, 1'b0, 128'd0, 16'h0, 1'b0, 6'h00,
                    4'b1110, 1'b1, 128'd0, 16'h1A2B, 1'b1, 6'h14};
        vecs[3] = '{1'b1, 9'd44, 3'd3, 1'b0, 2'b00, 1'b0, 128'd0, 16'h0, 1'b0, 6'h00,
                    4'b1110, 1'b1, 128'd0, 16'h0, 1'b0, 6'h00};
        vecs[4] = '{1'b0, 9'd5, 3'd0, 1'b1, 2'b00, 1'b0, L1, 16'h0, 1'b0, 6'h00,
                    4'b0000, 1'b0, 128'd0, 16'h0, 1'b0, 6'h00};
        vecs[5] = '{1'b1, 9'd5, 3'd0, 1'b1, 2'b00, 1'b0, L2, 16'h0, 1'b0, 6'h00,
                    4'b1101, 1'b1, L1, 16'h0, 1'b0, 6'h00};
        vecs[6] = '{1'b1, 9'd5, 3'd0, 1'b0, 2'b00, 1'b0, 128'd0, 16'h0, 1'b0, 6'h00,
                    4'b1001, 1'b1, L2, 16'h0, 1'b0, 6'h00};
        vecs[7] = '{1'b0, 9'd5, 3'd0, 1'b0, 2'b00, 1'b0, 128'd0, 16'h0, 1'b0, 6'h00,
                    4'b1001, 1'b0, L2, 16'h0, 1'b0, 6'h00};

        for (int i = 0; i < 8; i++) begin
            int w;
            w = int'(vecs[i].way);
            rd_en = vecs[i].rd_en; set_in = vecs[i].set; way_in = vecs[i].way;
            wr_en_line = vecs[i].wl; wr_en_state = vecs[i].ws; wr_en_tag = vecs[i].wt;
            wr_data_line = vecs[i].line; wr_data_tag = vecs[i].tag;
            wr_data_hprot = vecs[i].hprot; wr_data_state = vecs[i].state;
            tick();
            if (vecs[i].cmp[3]) check($sformatf("vec%0d_valid", i), 128'(rd_valid), 128'(vecs[i].exp_valid));
            if (vecs[i].cmp[2]) begin
                check($sformatf("vec%0d_tag", i), 128'(rd_data_tag[w*16 +: 16]), 128'(vecs[i].exp_tag));
                check($sformatf("vec%0d_hprot", i), 128'(rd_data_hprot[w]), 128'(vecs[i].exp_hprot));
            end
            if (vecs[i].cmp[1]) check($sformatf("vec%0d_state", i), 128'(rd_data_state[w*6 +: 6]), 128'(vecs[i].exp_state));
            if (vecs[i].cmp[0]) check($sformatf("vec%0d_line", i), rd_data_line[w*128 +: 128], vecs[i].exp_line);
        end
        clear_req();

        // Moving set_in to another bank after the read must not disturb the held output.
        read_set(9'd300);
        set_in = 9'd44;
        #1;
        check("set_change_same_cycle", 128'(rd_data_tag[3*16 +: 16]), 128'h1A2B);
        tick();
        check("set_change_next_cycle", 128'(rd_data_tag[3*16 +: 16]), 128'h1A2B);

        set_in = 9'd10; evict_advance = 1'b1;
        repeat (9) tick();
        clear_req();
        read_set(9'd10);
        check("evict_adv9", 128'(rd_data_evict_way), 128'd1);
        wr_en_evict_way = 1'b1; wr_data_evict_way = 3'd6; evict_advance = 1'b1;
        tick();
        clear_req();
        read_set(9'd10);
        check("evict_load_priority", 128'(rd_data_evict_way), 128'd6);
        evict_advance = 1'b1;
        read_set(9'd10);
        evict_advance = 1'b0;
        check("evict_read_before_adv", 128'(rd_data_evict_way), 128'd6);
        read_set(9'd10);
        check("evict_after_adv", 128'(rd_data_evict_way), 128'd7);
        evict_advance = 1'b1;
        tick();
        evict_advance = 1'b0;
        read_set(9'd10);
        check("evict_wrap", 128'(rd_data_evict_way), 128'd0);
        read_set(9'd11);
        check("evict_other_set", 128'(rd_data_evict_way), 128'd0);
        wr_en_evict_way = 1'b1; wr_data_evict_way = 3'd5; set_in = 9'd10;
        tick();
        clear_req();

        // Reset while a read is pending, then again in the middle of the init sweep.
        rd_en = 1'b1; set_in = 9'd300;
        tick();
        rd_en = 1'b0;
        check("pending_rd_valid", 128'(rd_valid), 128'd1);
        rst = 1'b0;
        #1;
        check("midread_rst_rd_valid", 128'(rd_valid), 128'd0);
        check("midread_rst_ready", 128'(ready), 128'd0);
        check("midread_rst_tags", rd_data_tag, 128'd0);
        tick();
        rst = 1'b1;
        repeat (100) tick();
        check("init100_not_ready", 128'(ready), 128'd0);
        rst = 1'b0;
        #1;
        check("midinit_rst_ready", 128'(ready), 128'd0);
        check("midinit_rst_rd_valid", 128'(rd_valid), 128'd0);
        tick();
        rst = 1'b1;
        wait_ready("reinit_cycles");

        read_set(9'd300);
        check("reinit_tag_cleared", 128'(rd_data_tag[3*16 +: 16]), 128'd0);
        check("reinit_state_cleared", 128'(rd_data_state[3*6 +: 6]), 128'd0);
        read_set(9'd10);
        check("reinit_evict_zero", 128'(rd_data_evict_way), 128'd0);
        read_set(9'd5);
        check("reinit_line_kept", rd_data_line[0 +: 128], L2);

`ifdef L2_LMEM_PARITY_EN
        way_in = 3'd2; set_in = 9'd7; wr_data_line = L1; wr_en_line = 1'b1;
        tick();
        clear_req();
        read_set(9'd7);
        check("parity_clean", 128'(parity_err), 128'd0);
        dut.g_way[2].u_way.line_mem[0][7][3] = ~dut.g_way[2].u_way.line_mem[0][7][3];
        read_set(9'd7);
        check("parity_valid", 128'(rd_valid), 128'd1);
        check("parity_way2", 128'(parity_err), 128'h04);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_localmem_banked.md
Name: l2_localmem_banked

Overview:
Parametrised L2 local memory holding, per set and way, the tag, hprot, per-word coherence state, line data and an evict-way pointer.
- Generalises the earlier fixed-geometry L2 local memory in five ways: configurable ways, sets, line width and SRAM bank depth; true per-word state storage instead of one replicated state; a hardware init sweep; a registered read-valid handshake; round-robin evict-way advance.
- Sits between the L2 controller pipeline and the sram_behav / GF12 macros.

Parameters:
NUM_WAYS, 8, ways per set (power of two)
NUM_SETS, 512, sets (power of two)
BANK_DEPTH, 256, sets per physical SRAM bank; NUM_SETS/BANK_DEPTH banks per way
WORDS_PER_LINE, 2, words per line
WORD_BITS, 64, bits per word; also the line-SRAM macro width
TAG_BITS, 16, tag width
STATE_BITS, 3, per-word state width
HPROT_BITS, 1, hprot width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
rd_en  in  1  read request for set_in, all ways
set_in  in  log2(NUM_SETS)  set address
way_in  in  log2(NUM_WAYS)  way for writes
wr_en_line  in  1  write line data to way_in
wr_en_state  in  WORDS_PER_LINE  per-word state write enables
wr_en_tag  in  1  write tag and hprot
wr_en_evict_way  in  1  load evict pointer with wr_data_evict_way
evict_advance  in  1  increment evict pointer of set_in modulo NUM_WAYS
wr_data_line  in  WORDS_PER_LINE*WORD_BITS  line data
wr_data_tag  in  TAG_BITS  tag
wr_data_hprot  in  HPROT_BITS  hprot
wr_data_state  in  WORDS_PER_LINE*STATE_BITS  packed states, word 0 in LSBs
wr_data_evict_way  in  log2(NUM_WAYS)  evict pointer value
ready  out  1  high when init done and accepting requests
rd_valid  out  1  read data valid
rd_data_line  out  NUM_WAYS*WORDS_PER_LINE*WORD_BITS  lines, way 0 in LSBs
rd_data_tag  out  NUM_WAYS*TAG_BITS  tags
rd_data_hprot  out  NUM_WAYS*HPROT_BITS  hprot
rd_data_state  out  NUM_WAYS*WORDS_PER_LINE*STATE_BITS  states
rd_data_evict_way  out  log2(NUM_WAYS)  evict pointer of the read set

Behaviour:
- Reset (rst low, async):
  - FSM enters INIT; ready=0, rd_valid=0.
  - All rd_data outputs 0; all evict pointers 0.
  - SRAM contents are not reset by rst.
- FSM INIT:
  - An internal counter walks sets 0..NUM_SETS-1, one set per cycle.
  - Each cycle writes tag=0, hprot=0 and all states=INVALID (0) to all ways of that set; line data is untouched.
  - After set NUM_SETS-1 is written, the FSM moves to IDLE and ready=1 on the next cycle.
  - INIT takes exactly NUM_SETS cycles after rst deasserts.
  - All request inputs are ignored while ready=0.
- FSM IDLE:
  - Bank select is set_in[MSBs]; SRAM address is set_in[log2(BANK_DEPTH)-1:0].
  - Only the selected bank of way_in is write-enabled.
  - State SRAM is bit-masked per word: word k is written only when wr_en_state[k]=1.
  - Tag, hprot and line are written with full masks.
- Reads:
  - rd_en at cycle N gives rd_valid=1 at N+1, with data from every way.
  - The bank mux uses set_in registered at N, so a set_in change at N+1 does not corrupt the output.
  - rd_data holds its last value while rd_valid=0.
- Same-cycle read and write to the same set:
  - The SRAM returns old data for the written way (read-before-write).
  - The evict pointer follows the same rule.
- Evict pointer:
  - wr_en_evict_way takes priority over evict_advance.
  - Advance wraps NUM_WAYS-1 -> 0.
- rst asserted mid-INIT or mid-read: the FSM restarts INIT from set 0, and any pending rd_valid is dropped.

Optional Feature:
L2_LMEM_PARITY_EN:
- When defined:
  - One even-parity bit is stored per line word and one per tag/hprot/state entry; SRAM widths grow by 1.
  - A parity check runs on read.
  - Output port parity_err (NUM_WAYS bits) is valid with rd_valid; bit w=1 on any mismatch in way w.
  - INIT writes correct parity for the tag/state entries.
- When undefined: no extra storage, and the parity_err port is absent.

Decomposition:
- Shared package l2_lmem_pkg holds:
  - the derived widths (SET_BITS, WAY_BITS, BANK_SEL_BITS);
  - the INVALID state constant;
  - the FSM enum {INIT, IDLE};
  - the packed entry typedef {hprot, state[WORDS_PER_LINE], tag}.
- Sub-module l2_lmem_way: one way, containing all banks for that way, the bank write decode and the registered read mux. The top instantiates NUM_WAYS copies of it plus the FSM and the evict-pointer array.

Test Plan:
- Init timing: release rst with NUM_SETS=512 -> ready rises 512 cycles later; a read of set 37 then returns all states 0 and tags 0, rd_valid 1 cycle after rd_en.
- Partial state write: write way 3, set 300 (bank 1), tag 0x1A2B, states {2,1}; then wr_en_state=2'b01 with state 4 -> read returns word0=4, word1=2; the same set index in bank 0 is unaffected.
- Read-before-write: rd_en and wr_en_line to set 5, way 0 in the same cycle -> old line returned; a read the next cycle returns the new line.
- Evict pointer: evict_advance x9 on set 10 with NUM_WAYS=8 -> pointer reads 1; wr_en_evict_way=6 together with evict_advance -> reads 6.
- Reset mid-INIT: assert rst at init cycle 100 -> ready=0 and rd_valid=0 immediately; after release, a full 512-cycle sweep completes before ready rises.
- Parity (L2_LMEM_PARITY_EN): force-flip a stored line bit of way 2 -> parity_err=8'b0000_0100 with rd_valid.
